// File: rtl/data_ram_if.sv
// Request/response bundle between the CPU load/store path (master) and data_ram_ctrl (slave).
interface data_ram_if #(
   parameter int ADDR_W = 8
);
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [1:0]        req_mode;
   logic              req_unsigned;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              resp_valid;
   logic [31:0]       resp_rdata;
   logic              resp_fault;
   logic              init_done;

   modport master (
      output req_valid, req_write, req_mode, req_unsigned, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_fault, init_done
   );

   modport slave (
      input  req_valid, req_write, req_mode, req_unsigned, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_fault, init_done
   );
endinterface

// File: rtl/data_ram_ctrl.sv
// Byte-addressed 32-bit-word data RAM with byte/half/word access, misalignment faults,
// configurable read latency and a post-reset clear sweep.
module data_ram_ctrl #(
   parameter int ADDR_W       = 8,
   parameter int READ_LATENCY = 1
) (
   input  logic      CLK,
   input  logic      reset,
   data_ram_if.slave bus
);
   localparam int WORD_AW   = ADDR_W - 2;
   localparam int WORDS     = 2 ** WORD_AW;
   localparam int WAIT_LOAD = (READ_LATENCY > 1) ? READ_LATENCY - 2 : 0;

   typedef enum logic [1:0] {
      ST_INIT = 2'd0,
      ST_IDLE = 2'd1,
      ST_WAIT = 2'd2,
      ST_RESP = 2'd3
   } state_t;

   state_t             state_r, state_next_s;
   logic [31:0]        mem_r [WORDS];
   logic [WORD_AW-1:0] cnt_r;
   logic [1:0]         wait_cnt_r;
   logic [31:0]        pend_data_r;
   logic               pend_fault_r;
   logic               req_ready_r, resp_valid_r, resp_fault_r, init_done_r;
   logic [31:0]        resp_rdata_r;
   logic               accept_s, fault_s, short_s;
   logic [WORD_AW-1:0] word_idx_s;
   logic [31:0]        rd_word_s, load_val_s;
   logic               wr_en_s;
   logic [WORD_AW-1:0] wr_idx_s;
   logic [31:0]        wr_data_s, wdata_rep_s;
   logic [3:0]         wr_mask_s;
   logic               ready_nxt_s, valid_nxt_s, init_nxt_s, fault_nxt_s;
   logic [31:0]        rdata_nxt_s;

   function automatic logic [3:0] lane_mask(input logic [1:0] mode, input logic [1:0] lo);
      logic [3:0] m;
      case (mode)
         2'b00:   m = 4'b0001 << lo;
         2'b01:   m = lo[1] ? 4'b1100 : 4'b0011;
         2'b10:   m = 4'b1111;
         default: m = 4'b0000;
      endcase
      return m;
   endfunction

   function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [1:0] mode,
                                               input logic [1:0] lo, input logic uns);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = word[{lo, 3'b000} +: 8];
      h = lo[1] ? word[31:16] : word[15:0];
      case (mode)
         2'b00:   r = {{24{b[7] & ~uns}}, b};
         2'b01:   r = {{16{h[15] & ~uns}}, h};
         2'b10:   r = word;
         default: r = 32'h0000_0000;
      endcase
      return r;
   endfunction

   assign word_idx_s = bus.req_addr[ADDR_W-1:2];
   assign rd_word_s  = mem_r[word_idx_s];

   // Request decode: fault check, accept event and the value a load will return
   always_comb begin
      case (bus.req_mode)
         2'b00:   fault_s = 1'b0;
         2'b01:   fault_s = bus.req_addr[0];
         2'b10:   fault_s = (bus.req_addr[1:0] != 2'b00);
         default: fault_s = 1'b1;
      endcase
      accept_s = (state_r == ST_IDLE) && bus.req_valid && req_ready_r;
      short_s  = bus.req_write || fault_s || (READ_LATENCY <= 1);
      if (bus.req_write || fault_s) begin
         load_val_s = 32'h0000_0000;
      end else begin
         load_val_s = extend_load(rd_word_s, bus.req_mode, bus.req_addr[1:0], bus.req_unsigned);
      end
   end

   // Single write port: clear sweep during INIT, lane-merged store otherwise
   always_comb begin
      wr_en_s   = 1'b0;
      wr_idx_s  = cnt_r;
      wr_data_s = 32'h0000_0000;
      wr_mask_s = lane_mask(bus.req_mode, bus.req_addr[1:0]);
      case (bus.req_mode)
         2'b00:   wdata_rep_s = {4{bus.req_wdata[7:0]}};
         2'b01:   wdata_rep_s = {2{bus.req_wdata[15:0]}};
         default: wdata_rep_s = bus.req_wdata;
      endcase
      if (state_r == ST_INIT) begin
         wr_en_s = 1'b1;
      end else if (accept_s && bus.req_write && !fault_s) begin
         wr_en_s  = 1'b1;
         wr_idx_s = word_idx_s;
         for (int i = 0; i < 4; i++) begin
            wr_data_s[8*i +: 8] = wr_mask_s[i] ? wdata_rep_s[8*i +: 8] : rd_word_s[8*i +: 8];
         end
      end else begin
         wr_en_s = 1'b0;
      end
   end

   // Memory array write; the array itself is cleared by the INIT sweep, not by reset
   always_ff @(posedge CLK) begin
      if (!reset && wr_en_s) begin
         mem_r[wr_idx_s] <= wr_data_s;
      end
   end

   // State register
   always_ff @(posedge CLK) begin
      if (reset) begin
         state_r <= ST_INIT;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_INIT: begin
            if (cnt_r == WORD_AW'(WORDS - 1)) state_next_s = ST_IDLE;
            else                              state_next_s = ST_INIT;
         end
         ST_IDLE: begin
            if (accept_s) state_next_s = short_s ? ST_RESP : ST_WAIT;
            else          state_next_s = ST_IDLE;
         end
         ST_WAIT: begin
            if (wait_cnt_r == 2'd0) state_next_s = ST_RESP;
            else                    state_next_s = ST_WAIT;
         end
         ST_RESP: state_next_s = ST_IDLE;
         default: state_next_s = ST_INIT;
      endcase
   end

   // Output logic, evaluated one cycle ahead so that every output comes from a flop
   always_comb begin
      ready_nxt_s = (state_next_s == ST_IDLE);
      valid_nxt_s = (state_next_s == ST_RESP);
      init_nxt_s  = (state_next_s != ST_INIT);
      if (accept_s) begin
         rdata_nxt_s = load_val_s;
         fault_nxt_s = fault_s;
      end else begin
         rdata_nxt_s = pend_data_r;
         fault_nxt_s = pend_fault_r;
      end
   end

   // Output registers; response data holds between pulses
   always_ff @(posedge CLK) begin
      if (reset) begin
         req_ready_r  <= 1'b0;
         resp_valid_r <= 1'b0;
         init_done_r  <= 1'b0;
         resp_rdata_r <= 32'h0000_0000;
         resp_fault_r <= 1'b0;
      end else begin
         req_ready_r  <= ready_nxt_s;
         resp_valid_r <= valid_nxt_s;
         init_done_r  <= init_nxt_s;
         if (valid_nxt_s) begin
            resp_rdata_r <= rdata_nxt_s;
            resp_fault_r <= fault_nxt_s;
         end
      end
   end

   // Clear counter, latency countdown and captured response
   always_ff @(posedge CLK) begin
      if (reset) begin
         cnt_r        <= '0;
         wait_cnt_r   <= 2'd0;
         pend_data_r  <= 32'h0000_0000;
         pend_fault_r <= 1'b0;
      end else begin
         if (state_r == ST_INIT) cnt_r <= cnt_r + 1'b1;
         if (accept_s) begin
            pend_data_r  <= load_val_s;
            pend_fault_r <= fault_s;
            wait_cnt_r   <= 2'(WAIT_LOAD);
         end else if (state_r == ST_WAIT && wait_cnt_r != 2'd0) begin
            wait_cnt_r <= wait_cnt_r - 2'd1;
         end
      end
   end

   assign bus.req_ready  = req_ready_r;
   assign bus.resp_valid = resp_valid_r;
   assign bus.resp_rdata = resp_rdata_r;
   assign bus.resp_fault = resp_fault_r;
   assign bus.init_done  = init_done_r;
endmodule
